wb_io_channel_mux: RTL

//   Wishbone-controlled router that selects one of N_CH user channels to drive the shared IO pads.
//   It is the multi-channel successor to the single-design project wrapper.
//   A guard-blanked switchover FSM prevents glitches on the pads when the channel changes.
//   Per-pin output-enable override and latched, maskable per-channel IRQs are included.

---
 rtl/wb_io_channel_mux_if.sv | 22 ++
 rtl/wb_io_channel_mux.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/wb_io_channel_mux_if.sv
// Wishbone slave bus bundle for wb_io_channel_mux.
// The clock and reset stay outside the bundle as plain ports.
interface wb_io_channel_mux_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_io_channel_mux.sv
// Wishbone-controlled router driving the shared IO pads from one of N_CH user channels,
// with guard-blanked channel switchover, per-pin oeb override and latched maskable IRQs.
module wb_io_channel_mux #(
  parameter int          N_CH     = 4,
  parameter int          IO_W     = 16,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int          GUARD    = 4
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  wb_io_channel_mux_if.slave   wbs,
  input  logic                 active,
  input  logic [N_CH*IO_W-1:0] ch_io_out,
  input  logic [N_CH*IO_W-1:0] ch_io_oeb,
  input  logic [N_CH-1:0]      ch_irq,
  output logic [IO_W-1:0]      io_out,
  output logic [IO_W-1:0]      io_oeb,
  output logic [2:0]           irq
);
  localparam int               CNT_W      = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(GUARD - 1);
  localparam logic [5:0]       OFF_CTRL   = 6'd0;
  localparam logic [5:0]       OFF_OEB    = 6'd1;
  localparam logic [5:0]       OFF_STAT   = 6'd2;
  localparam logic [5:0]       OFF_IEN    = 6'd3;
  localparam logic [5:0]       OFF_STATUS = 6'd4;

  typedef enum logic {ST_RUN, ST_BLANK} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_switch_done;

  logic             r_ack;
  logic [31:0]      r_dat;
  logic [3:0]       r_ctrl_sel, r_live_sel;
  logic             r_ctrl_en, r_live_en;
  logic [IO_W-1:0]  r_oeb_force;
  logic [N_CH-1:0]  r_irq_stat, r_irq_en, r_irq_prev;
  logic [IO_W-1:0]  r_io_out, r_io_oeb;
  logic             r_irq0, r_irq1;

  logic [5:0]       w_offset;
  logic             w_hit, w_req, w_wr, w_ctrl_chg, w_blanking, w_unused;
  logic [31:0]      w_bmask, w_dat_m, w_ctrl_rd, w_ctrl_wd, w_oeb_wd, w_ien_wd, w_rdata;
  logic [3:0]       w_new_sel;
  logic [N_CH-1:0]  w_w1c, w_rise;
  logic [IO_W-1:0]  w_ch_out, w_ch_oeb;

  assign w_offset   = wbs.wbs_adr_i[7:2];
  assign w_hit      = (wbs.wbs_adr_i[31:8] == BASE_ADR[31:8]) && (w_offset <= OFF_STATUS);
  // The !r_ack term spaces back-to-back requests so each ack is a single-cycle pulse.
  assign w_req      = wbs.wbs_stb_i && wbs.wbs_cyc_i && active && w_hit && !r_ack;
  assign w_wr       = w_req && wbs.wbs_we_i;
  assign w_bmask    = {{8{wbs.wbs_sel_i[3]}}, {8{wbs.wbs_sel_i[2]}},
                       {8{wbs.wbs_sel_i[1]}}, {8{wbs.wbs_sel_i[0]}}};
  assign w_dat_m    = wbs.wbs_dat_i & w_bmask;
  assign w_ctrl_rd  = {23'd0, r_ctrl_en, 4'd0, r_ctrl_sel};
  assign w_ctrl_wd  = w_dat_m | (w_ctrl_rd & ~w_bmask);
  assign w_oeb_wd   = w_dat_m | (32'(r_oeb_force) & ~w_bmask);
  assign w_ien_wd   = w_dat_m | (32'(r_irq_en) & ~w_bmask);
  assign w_new_sel  = ({28'd0, w_ctrl_wd[3:0]} >= 32'(N_CH)) ? 4'(N_CH - 1) : w_ctrl_wd[3:0];
  assign w_ctrl_chg = w_wr && (w_offset == OFF_CTRL) &&
                      ((w_new_sel != r_ctrl_sel) || (w_ctrl_wd[8] != r_ctrl_en));
  assign w_w1c      = (w_wr && (w_offset == OFF_STAT)) ? w_dat_m[N_CH-1:0] : '0;
  assign w_rise     = ch_irq & ~r_irq_prev;
  assign w_blanking = (r_state == ST_BLANK);
  assign w_unused   = &{1'b0, wbs.wbs_adr_i[1:0], w_ctrl_wd, w_oeb_wd, w_ien_wd, w_dat_m};

  always_comb begin
    w_rdata = '0;
    case (w_offset)
      OFF_CTRL:   w_rdata = w_ctrl_rd;
      OFF_OEB:    w_rdata = 32'(r_oeb_force);
      OFF_STAT:   w_rdata = 32'(r_irq_stat);
      OFF_IEN:    w_rdata = 32'(r_irq_en);
      OFF_STATUS: w_rdata = {23'd0, w_blanking, 4'd0, r_live_sel};
      default:    w_rdata = '0;
    endcase
  end

  always_comb begin
    w_ch_out = '0;
    w_ch_oeb = '1;
    for (int k = 0; k < N_CH; k++) begin
      if (r_live_sel == 4'(k)) begin
        w_ch_out = ch_io_out[k*IO_W +: IO_W];
        w_ch_oeb = ch_io_oeb[k*IO_W +: IO_W];
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_switch_done = 1'b0;
    if (w_ctrl_chg) begin
      w_state_nxt = ST_BLANK;
      w_cnt_nxt   = CNT_LOAD;
    end else if (r_state == ST_BLANK) begin
      if (r_cnt == '0) begin
        w_state_nxt   = ST_RUN;
        w_switch_done = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt - 1'b1;
      end
    end
  end

  // NOTE: non-blocking assignments keep every register sampling the pre-edge values of the others.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ack       <= 1'b0;
      r_dat       <= '0;
      r_ctrl_sel  <= '0;
      r_ctrl_en   <= 1'b0;
      r_live_sel  <= '0;
      r_live_en   <= 1'b0;
      r_oeb_force <= '0;
      r_irq_stat  <= '0;
      r_irq_en    <= '0;
      r_irq_prev  <= '0;
    end else begin
      r_ack <= w_req;
      r_dat <= (w_req && !wbs.wbs_we_i) ? w_rdata : '0;
      if (w_wr && (w_offset == OFF_CTRL)) begin
        r_ctrl_sel <= w_new_sel;
        r_ctrl_en  <= w_ctrl_wd[8];
      end
      if (w_wr && (w_offset == OFF_OEB)) r_oeb_force <= w_oeb_wd[IO_W-1:0];
      if (w_wr && (w_offset == OFF_IEN)) r_irq_en <= w_ien_wd[N_CH-1:0];
      if (w_switch_done) begin
        r_live_sel <= r_ctrl_sel;
        r_live_en  <= r_ctrl_en;
      end
      r_irq_prev <= ch_irq;
      // A fresh edge is ORed in after the clear, so it survives a same-cycle W1C.
      r_irq_stat <= (r_irq_stat & ~w_w1c) | w_rise;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_io_out <= '0;
      r_io_oeb <= '1;
      r_irq0   <= 1'b0;
      r_irq1   <= 1'b0;
    end else begin
      if (!active || w_blanking || !r_live_en) begin
        r_io_out <= '0;
        r_io_oeb <= '1;
      end else begin
        r_io_out <= w_ch_out;
        r_io_oeb <= w_ch_oeb | r_oeb_force;
      end
      r_irq0 <= active && |(r_irq_stat & r_irq_en);
      r_irq1 <= active && w_switch_done;
    end
  end

  assign wbs.wbs_ack_o = r_ack;
  assign wbs.wbs_dat_o = r_dat;
  assign io_out        = r_io_out;
  assign io_oeb        = r_io_oeb;
  assign irq           = {1'b0, r_irq1, r_irq0};
endmodule
